// File: rtl/k12a_memory_ctrl_if.sv
// Request/device bus for k12a_memory_ctrl: CPU-side request signals plus the
// external memory strobes and data buses.
interface k12a_memory_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  ready;
  logic                  err;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  mem_doe;
  logic [DATA_WIDTH-1:0] mem_din;
  logic                  rom_ce_n;
  logic                  ram_ce_n;
  logic                  oe_n;
  logic                  we_n;

  modport master (
    output req, write, addr, wdata, mem_din,
    input  busy, ready, err, rdata, mem_addr, mem_dout, mem_doe,
    input  rom_ce_n, ram_ce_n, oe_n, we_n
  );

  modport slave (
    input  req, write, addr, wdata, mem_din,
    output busy, ready, err, rdata, mem_addr, mem_dout, mem_doe,
    output rom_ce_n, ram_ce_n, oe_n, we_n
  );
endinterface

// File: rtl/k12a_memory_ctrl.sv
// ROM/RAM strobe sequencer: SETUP, WAIT_STATES-cycle STROBE, HOLD, DONE.
// Optional macro K12A_MEM_WRITE_PROTECT_EN blocks ROM writes and flags them with err.
module k12a_memory_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned RAM_BASE    = 'h8000,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic             clock,
  input logic             reset_n,
  k12a_memory_ctrl_if.slave bus
);

`ifdef K12A_MEM_WRITE_PROTECT_EN
  localparam bit WriteProtect = 1'b1;
`else
  localparam bit WriteProtect = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] RamBase = ADDR_WIDTH'(RAM_BASE);
  localparam logic [3:0]            CntLoad = 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  write_q;
  logic                  ram_q;
  logic                  busy_q;
  logic                  ready_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_dout_q;
  logic                  mem_doe_q;
  logic                  rom_ce_n_q;
  logic                  ram_ce_n_q;
  logic                  oe_n_q;
  logic                  we_n_q;

  logic addr_is_ram;
  logic write_allowed;

  assign addr_is_ram   = (bus.addr >= RamBase);
  assign write_allowed = ram_q | ~WriteProtect;

  // Outputs are registered: each transition sets the strobes of the state being entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      ram_q      <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      mem_doe_q  <= 1'b0;
      rom_ce_n_q <= 1'b1;
      ram_ce_n_q <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req) begin
            state_q    <= StSetup;
            write_q    <= bus.write;
            ram_q      <= addr_is_ram;
            mem_addr_q <= bus.addr;
            mem_dout_q <= bus.wdata;
            busy_q     <= 1'b1;
            rom_ce_n_q <= addr_is_ram;
            ram_ce_n_q <= ~addr_is_ram;
            oe_n_q     <= bus.write;
            mem_doe_q  <= bus.write;
          end
        end
        StSetup: begin
          state_q <= StStrobe;
          cnt_q   <= CntLoad;
          we_n_q  <= ~(write_q & write_allowed);
        end
        StStrobe: begin
          if (cnt_q == 4'd0) begin
            state_q <= StHold;
            // we_n rises a cycle ahead of ce_n and mem_doe.
            we_n_q  <= 1'b1;
            if (!write_q) begin
              rdata_q <= bus.mem_din;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StHold: begin
          state_q    <= StDone;
          rom_ce_n_q <= 1'b1;
          ram_ce_n_q <= 1'b1;
          oe_n_q     <= 1'b1;
          mem_doe_q  <= 1'b0;
          ready_q    <= 1'b1;
          err_q      <= write_q & ~write_allowed;
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
  assign bus.err      = err_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_doe  = mem_doe_q;
  assign bus.rom_ce_n = rom_ce_n_q;
  assign bus.ram_ce_n = ram_ce_n_q;
  assign bus.oe_n     = oe_n_q;
  assign bus.we_n     = we_n_q;

endmodule

// File: tb/tb_k12a_memory_ctrl.sv
// Randomised scoreboard bench for k12a_memory_ctrl with a cycle-offset reference model
// and a simple memory device. Honours K12A_MEM_WRITE_PROTECT_EN and the WAIT_STATES parameter.
module tb_k12a_memory_ctrl;
  parameter int unsigned WAIT_STATES = 2;

  localparam int WS = int'(WAIT_STATES);
  localparam logic [15:0] RAM_BASE = 16'h8000;
`ifdef K12A_MEM_WRITE_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  k12a_memory_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  k12a_memory_ctrl #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (8),
    .RAM_BASE   ('h8000),
    .WAIT_STATES(WAIT_STATES)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int accepts = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Reference model: the access in flight, described by its sampling edge.
  bit          act_valid = 1'b0;
  int          act_s = 0;
  bit          act_w, act_rom;
  logic [7:0]  act_rd = '0, act_prev_rd = '0, last_rd = '0;
  logic [15:0] exp_maddr = '0;
  logic [7:0]  exp_mdout = '0;

  typedef struct {
    logic [7:0] rd;
    bit         err;
    int         done_edge;
  } exp_t;
  exp_t sb[$];

  logic [7:0] ref_mem [int];
  logic [7:0] dev_mem [int];

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic logic [7:0] dev_rd(input logic [15:0] a);
    return dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : init_val(a);
  endfunction

  function automatic bit model_idle();
    return !act_valid || (edge_cnt >= act_s + WS + 3);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic accept(input bit w, input logic [15:0] a, input logic [7:0] d);
    exp_t x;
    accepts++;
    act_valid   = 1'b1;
    act_s       = edge_cnt + 1;
    act_w       = w;
    act_rom     = (a < RAM_BASE);
    act_prev_rd = last_rd;
    if (!w) begin
      act_rd  = ref_rd(a);
      last_rd = act_rd;
    end else begin
      act_rd = last_rd;
      if (!(PROTECT && act_rom)) ref_mem[int'(a)] = d;
    end
    exp_maddr   = a;
    exp_mdout   = d;
    x.rd        = last_rd;
    x.err       = w && PROTECT && act_rom;
    x.done_edge = act_s + WS + 2;
    sb.push_back(x);
  endtask

  // One cycle: device acts on the bus, then new request inputs are driven.
  task automatic step(input bit r, input bit w, input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    if (bus.we_n === 1'b0) dev_mem[int'(bus.mem_addr)] = bus.mem_dout;
    bus.mem_din = dev_rd(bus.mem_addr);
    bus.req   = r;
    bus.write = w;
    bus.addr  = a;
    bus.wdata = d;
    if (r && reset_n && model_idle()) accept(w, a, d);
  endtask

  task automatic do_access(input bit w, input logic [15:0] a, input logic [7:0] d);
    while (!model_idle()) step(1'b0, 1'b0, 16'h0, 8'h0);
    step(1'b1, w, a, d);
  endtask

  // Per-cycle protocol checker: strobes, busy, pulses and held buses.
  initial begin : protocol_chk
    int o;
    bit ce, e_ready;
    logic [39:0] e_vec, a_vec;
    forever begin
      @(posedge clock);
      #2;
      o       = act_valid ? edge_cnt - act_s : -1;
      ce      = act_valid && o >= 0 && o <= WS + 1;
      e_ready = act_valid && o == WS + 2;
      e_vec = {act_valid && o >= 0 && o <= WS + 2,
               e_ready,
               e_ready && PROTECT && act_w && act_rom,
               !(ce && act_rom),
               !(ce && !act_rom),
               !(ce && !act_w),
               !(act_valid && act_w && !(PROTECT && act_rom) && o >= 1 && o <= WS),
               ce && act_w,
               exp_maddr,
               exp_mdout,
               (act_valid && !act_w && o >= WS + 1) ? act_rd : act_prev_rd};
      a_vec = {bus.busy, bus.ready, bus.err, bus.rom_ce_n, bus.ram_ce_n, bus.oe_n, bus.we_n,
               bus.mem_doe, bus.mem_addr, bus.mem_dout, bus.rdata};
      check("bus_state", 64'(a_vec), 64'(e_vec));
      check("ce_overlap", 64'(!bus.rom_ce_n && !bus.ram_ce_n), 64'd0);
    end
  end

  // Scoreboard monitor: pops one expectation per ready pulse.
  initial begin : sb_monitor
    exp_t x;
    forever begin
      @(posedge clock);
      #2;
      if (bus.ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready at edge %0d: got ready=1 expected no pending access",
                   edge_cnt);
        end else begin
          x = sb.pop_front();
          check("ready_edge", 64'(edge_cnt), 64'(x.done_edge));
          check("rdata", 64'(bus.rdata), 64'(x.rd));
          check("err", 64'(bus.err), 64'(x.err));
        end
      end
    end
  end

  initial begin : stimulus
    logic [15:0] pool [8];
    logic [15:0] a;
    logic [7:0]  d;
    int base;
    bus.req = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0; bus.mem_din = '0;
    ref_mem[16'h0123] = 8'h5A;
    dev_mem[16'h0123] = 8'h5A;
    pool = '{16'h0000, 16'h0010, 16'h0123, 16'h7FFF, 16'h8000, 16'h8004, 16'hFFFF, 16'hC000};

    repeat (3) step(1'b0, 1'b0, 16'h0, 8'h0);
    reset_n = 1'b1;

    do_access(1'b0, 16'h0123, 8'h00);
    do_access(1'b1, 16'h8004, 8'hC3);
    do_access(1'b0, 16'h8004, 8'h00);
    do_access(1'b1, 16'h0010, 8'hFF);
    do_access(1'b0, 16'h0010, 8'h00);

    // req held high across two reads; the second must wait for IDLE.
    while (!model_idle()) step(1'b0, 1'b0, 16'h0, 8'h0);
    base = accepts;
    for (int i = 0; i < 2 * (WS + 4); i++) begin
      a = (accepts == base) ? 16'h8000 : 16'h7FFF;
      step(1'b1, 1'b0, a, 8'h00);
    end
    check("held_req_accepts", 64'(accepts - base), 64'd2);

    // Reset during STROBE of a RAM write; data matches memory so a partial write is harmless.
    a = 16'h9000;
    d = ref_rd(a);
    do_access(1'b1, a, d);
    step(1'b0, 1'b0, 16'h0, 8'h0);
    step(1'b0, 1'b0, 16'h0, 8'h0);
    check("abort_we_low", 64'(bus.we_n), 64'd0);
    reset_n = 1'b0;
    act_valid = 1'b0;
    void'(sb.pop_back());
    exp_maddr = '0; exp_mdout = '0; act_prev_rd = '0; last_rd = '0;
    #1;
    check("abort_strobes",
          64'({bus.we_n, bus.ram_ce_n, bus.rom_ce_n, bus.oe_n, bus.mem_doe, bus.busy, bus.ready}),
          64'(7'b1111000));
    step(1'b0, 1'b0, 16'h0, 8'h0);
    reset_n = 1'b1;
    do_access(1'b0, a, 8'h00);

    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pool[$urandom_range(0, 7)];
      step($urandom_range(0, 2) == 0, 1'($urandom), a, 8'($urandom));
    end

    while (!model_idle()) step(1'b0, 1'b0, 16'h0, 8'h0);
    repeat (4) step(1'b0, 1'b0, 16'h0, 8'h0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
